// File: rtl/poly_accumulator_if.sv
// Handshake/data bundle between the polynomial multiplier and poly_accumulator.
// slave: accumulator side; master: producer/consumer side.
interface poly_accumulator_if #(
    parameter int unsigned N = 4,
    parameter int unsigned q = 10,
    parameter int unsigned K = 2
);
    localparam int unsigned CntW = $clog2(K) + 1;

    logic            in_valid;
    logic            in_ready;
    logic [q-1:0]    in_0, in_1, in_2, in_3;
    logic [q-1:0]    b_0, b_1, b_2, b_3;
    logic            out_valid;
    logic            out_ready;
    logic [q-1:0]    acc_0, acc_1, acc_2, acc_3;
    logic [N-1:0]    dec;
    logic [CntW-1:0] beat_cnt;

    modport slave (
        input  in_valid, in_0, in_1, in_2, in_3, b_0, b_1, b_2, b_3, out_ready,
        output in_ready, out_valid, acc_0, acc_1, acc_2, acc_3, dec, beat_cnt
    );

    modport master (
        output in_valid, in_0, in_1, in_2, in_3, b_0, b_1, b_2, b_3, out_ready,
        input  in_ready, out_valid, acc_0, acc_1, acc_2, acc_3, dec, beat_cnt
    );
endinterface

// File: rtl/poly_accumulator.sv
// Sums K product polynomials plus a bias polynomial mod 2^q, then holds the result.
// Optional message decode is enabled by defining POLY_ACC_DECODE_EN.
module poly_accumulator #(
    parameter int unsigned N = 4,
    parameter int unsigned q = 10,
    parameter int unsigned K = 2
) (
    input logic                clk,
    input logic                rst,
    poly_accumulator_if.slave  bus
);
    localparam int unsigned     CntW    = $clog2(K) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(K - 1);

    typedef enum logic {StAcc, StFull} state_e;

    state_e          r_state, w_state_nxt;
    logic [CntW-1:0] r_cnt, w_cnt_nxt;
    logic [q-1:0]    r_acc [N];
    logic [q-1:0]    w_in  [N];
    logic [q-1:0]    w_b   [N];
    logic [q-1:0]    w_sum [N];
    logic            w_accept;

    assign w_in[0] = bus.in_0;
    assign w_in[1] = bus.in_1;
    assign w_in[2] = bus.in_2;
    assign w_in[3] = bus.in_3;
    assign w_b[0]  = bus.b_0;
    assign w_b[1]  = bus.b_1;
    assign w_b[2]  = bus.b_2;
    assign w_b[3]  = bus.b_3;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            StAcc: begin
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    if (r_cnt == LastCnt) begin
                        w_state_nxt = StFull;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CntW'(1);
                    end
                end
            end
            StFull: begin
                if (bus.out_ready) begin
                    w_state_nxt = StAcc;
                end
            end
            default: w_state_nxt = StAcc;
        endcase
    end

    // First beat of a result starts from the bias instead of the stale sum.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_sum[i] = ((r_cnt == '0) ? w_b[i] : r_acc[i]) + w_in[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StAcc;
            r_cnt   <= '0;
            for (int i = 0; i < N; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                for (int i = 0; i < N; i++) begin
                    r_acc[i] <= w_sum[i];
                end
            end
        end
    end

    assign bus.in_ready  = (r_state == StAcc);
    assign bus.out_valid = (r_state == StFull);
    assign bus.beat_cnt  = r_cnt;
    assign bus.acc_0     = r_acc[0];
    assign bus.acc_1     = r_acc[1];
    assign bus.acc_2     = r_acc[2];
    assign bus.acc_3     = r_acc[3];

`ifdef POLY_ACC_DECODE_EN
    // Two MSBs differ exactly when acc lies nearer 2^(q-1) than 0.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.dec[i] = r_acc[i][q-1] ^ r_acc[i][q-2];
        end
    end
`else
    assign bus.dec = '0;
`endif

endmodule

// File: tb/tb_poly_accumulator.sv
// Directed self-checking bench for poly_accumulator (N=4, q=10, K=2).
module tb_poly_accumulator;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    poly_accumulator_if #(.N(4), .q(10), .K(2)) bus ();

    poly_accumulator #(.N(4), .q(10), .K(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_acc(input string tag, input int e0, input int e1, input int e2,
                             input int e3);
        check({tag, ".acc0"}, 32'(bus.acc_0), 32'(e0));
        check({tag, ".acc1"}, 32'(bus.acc_1), 32'(e1));
        check({tag, ".acc2"}, 32'(bus.acc_2), 32'(e2));
        check({tag, ".acc3"}, 32'(bus.acc_3), 32'(e3));
    endtask

    task automatic set_in(input int a0, input int a1, input int a2, input int a3);
        bus.in_0 = 10'(a0);
        bus.in_1 = 10'(a1);
        bus.in_2 = 10'(a2);
        bus.in_3 = 10'(a3);
    endtask

    task automatic set_b(input int a0, input int a1, input int a2, input int a3);
        bus.b_0 = 10'(a0);
        bus.b_1 = 10'(a1);
        bus.b_2 = 10'(a2);
        bus.b_3 = 10'(a3);
    endtask

    // Present one beat for one clock; called #1 after a posedge while in ACC.
    task automatic beat(input int a0, input int a1, input int a2, input int a3);
        set_in(a0, a1, a2, a3);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        set_in(9, 9, 9, 9);
        set_b(7, 7, 7, 7);

        // Reset held two cycles with beats presented
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_acc("rst", 0, 0, 0, 0);
        check("rst.out_valid", 32'(bus.out_valid), 0);
        check("rst.beat_cnt", 32'(bus.beat_cnt), 0);
        check("rst.dec", 32'(bus.dec), 0);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst.in_ready", 32'(bus.in_ready), 1);
        check_acc("rst_rel", 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // Basic accumulation
        set_b(1, 2, 3, 4);
        beat(10, 20, 30, 40);
        check("basic.cnt1", 32'(bus.beat_cnt), 1);
        check("basic.ov1", 32'(bus.out_valid), 0);
        check_acc("basic1", 11, 22, 33, 44);
        set_b(0, 0, 0, 0);
        beat(100, 200, 300, 400);
        check("basic.ov2", 32'(bus.out_valid), 1);
        check("basic.ir2", 32'(bus.in_ready), 0);
        check("basic.cnt2", 32'(bus.beat_cnt), 0);
        check_acc("basic2", 111, 222, 333, 444);
        consume();
        check("basic.ov_done", 32'(bus.out_valid), 0);
        check("basic.ir_done", 32'(bus.in_ready), 1);
        check_acc("basic_hold", 111, 222, 333, 444);

        // Modular wrap
        set_b(0, 0, 0, 0);
        beat(1000, 1023, 512, 0);
        beat(30, 1, 512, 5);
        check("wrap.ov", 32'(bus.out_valid), 1);
        check_acc("wrap", 6, 0, 0, 5);

        // Backpressure with in_valid asserted
        set_b(50, 60, 70, 80);
        set_in(7, 7, 7, 7);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp.in_ready", 32'(bus.in_ready), 0);
            check("bp.out_valid", 32'(bus.out_valid), 1);
            check("bp.cnt", 32'(bus.beat_cnt), 0);
            check_acc("bp", 6, 0, 0, 5);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("bp.rel_ir", 32'(bus.in_ready), 1);
        check("bp.rel_ov", 32'(bus.out_valid), 0);
        check_acc("bp.no_accept", 6, 0, 0, 5);
        @(posedge clk);
        #1;
        check_acc("bp.first", 57, 67, 77, 87);
        set_in(1, 1, 1, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp.ov2", 32'(bus.out_valid), 1);
        check_acc("bp.result", 58, 68, 78, 88);
        consume();

        // Reset mid-accumulation
        set_b(1, 1, 1, 1);
        beat(5, 5, 5, 5);
        check("mid.cnt", 32'(bus.beat_cnt), 1);
        check_acc("mid.partial", 6, 6, 6, 6);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid.cnt_rst", 32'(bus.beat_cnt), 0);
        check("mid.ir", 32'(bus.in_ready), 1);
        check_acc("mid.rst", 0, 0, 0, 0);
        set_b(2, 3, 4, 5);
        beat(10, 10, 10, 10);
        set_b(0, 0, 0, 0);
        beat(1, 1, 1, 1);
        check("mid.ov", 32'(bus.out_valid), 1);
        check_acc("mid.result", 13, 14, 15, 16);
        consume();

        // Decode
        set_b(0, 0, 0, 0);
        beat(0, 256, 511, 768);
        beat(0, 0, 0, 0);
        check_acc("dec", 0, 256, 511, 768);
`ifdef POLY_ACC_DECODE_EN
        check("dec.bits", 32'(bus.dec), 32'h6);
`else
        check("dec.bits", 32'(bus.dec), 32'h0);
`endif
        consume();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
